alu_digit_serial: RTL and testbench
===================================

// Module: alu_digit_serial
// PURPOSE
//  Parametrised, nibble-serial ALU; the wide-word successor of the 8-bit datapath ALU.
//  Performs binary/BCD add and subtract, logic ops and shift right on WIDTH-bit operands, one 4-bit digit per clock, LSB digit first.
//  Results and flags are returned through a start/busy/done handshake.
//  Serves the extended-precision arithmetic unit, which issues one operation at a time.
// PARAMETERS
//  WIDTH   16  operand/result width; multiple of 4, >= 4; DIGITS = WIDTH/4 (localparam)
// PORTS
//  clk_2       in   1      single system clock; all state updates on rising edge
//  res_n       in   1      asynchronous, active-low reset
//  start       in   1      request; sampled only while idle (busy=0)
//  op          in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 EOR, 5 SR, 6-7 PASS (result=a)
//  decimal     in   1      BCD mode for ADD/SUB; ignored for other ops
//  carry_in    in   1      carry in (ADD); not-borrow in (SUB, 1 = no borrow)
//  a, b        in   WIDTH  operands, captured on accepted start
//  busy        out  1      high from cycle after accept until done cycle inclusive
//  done        out  1      one-cycle pulse: result/flags valid
//  result      out  WIDTH  true-polarity result (not inverted), held until next accept
//  carry_out   out  1      final carry / not-borrow / shifted-out bit
//  overflow    out  1      signed overflow (ADD/SUB only, else 0)
//  half_carry  out  1      carry out of digit 0 (after decimal adjust when decimal=1)
//  zero        out  1      result == 0
//  negative    out  1      result[WIDTH-1]
// BEHAVIOUR
//  - Reset (res_n low, async): state IDLE; busy, done, result, carry_out, overflow, half_carry and negative = 0; zero = 1.
//    Operand regs and the digit counter clear.
//  - FSM: IDLE -> RUN on start & !busy. Operands, op, decimal and carry_in are latched; digit counter = 0.
//    RUN: one digit per clock; counter++; after digit DIGITS-1 -> DONE.
//    DONE: done=1 for one cycle, flags and result final -> IDLE.
//  - Latency: accept at edge N; done high in cycle N+DIGITS+1. For WIDTH=16, done is high 5 cycles after the accept edge.
//    Back-to-back: start may be high in the DONE cycle; it is accepted at the following edge.
//  - start while busy: ignored, no effect on the operation in flight.
//    Operand/op inputs may change freely after accept.
//  - Digit i uses a_i and b_i = operand bits [4i+3:4i]. Internal carry c starts at carry_in.
//  - ADD bin: s = a_i + b_i + c (5 bits); digit = s[3:0]; c = s[4].
//  - SUB bin: same, with b_i replaced by ~b_i.
//  - ADD dec: s = a_i + b_i + c; if s > 9 then s += 6 and c = 1, else c = 0; digit = s[3:0].
//  - SUB dec: s = a_i + ~b_i + c; c = s[4]; if c == 0 then digit = s[3:0] - 6 (mod 16), else digit = s[3:0].
//  - Non-BCD digits (>9) in decimal mode: the same rules apply mechanically; no error is flagged.
//  - half_carry = c after digit 0. carry_out = c after digit DIGITS-1.
//  - overflow (ADD/SUB): from the top digit's binary sum before decimal adjust.
//    V = (a_msb == b'_msb) & (bin_sum_msb != a_msb), with b' = ~b for SUB.
//  - AND/OR/EOR: bitwise per digit; carry_out = carry_in; overflow = 0; half_carry = 0.
//  - SR: logical shift right by one. Digit i = {a[4i+4], a[4i+3:4i+1]}, with a[WIDTH] := 0.
//    carry_out = a[0]; overflow = 0; half_carry = 0.
//  - PASS (op 6,7): result = a; carry_out = carry_in; overflow = 0; half_carry = 0.
//  - zero and negative: evaluated on the final assembled result in DONE, for all ops.
//  - Outputs change only in the DONE cycle. During RUN, result/flags keep the previous operation's values;
//    partial digits live in an internal shadow register.
//  - Reset mid-RUN: immediate abort to the reset state; no done pulse is issued.
// TESTING
//  1. WIDTH=16, ADD bin, a=7FFF, b=0001, cin=0 -> result 8000, V=1, N=1, C=0, Z=0; done exactly 5 cycles after accept.
//  2. ADD dec, a=0999, b=0001, cin=0 -> result 1000, C=0, H=1, V=0; SUB dec, a=0000, b=0001, cin=1 -> 9999, C=0.
//  3. SUB bin, a=1234, b=1234, cin=1 -> 0000, Z=1, C=1, V=0; SR a=8001 -> 4000, C=1, N=0.
//  4. Pulse start with new operands during RUN -> ignored, first result unchanged.
//     Start held high in the DONE cycle -> second op accepted, its done 5 cycles later.
//  5. Assert res_n low mid-RUN -> all outputs at reset values immediately, no done pulse; normal op afterwards.
//  6. WIDTH=8 instance: ADD dec, 99+01 -> 00, C=1, Z=1; done 3 cycles after accept.

Source files
------------

// File: rtl/alu_digit_serial.sv
// Nibble-serial ALU: binary/BCD add and subtract, logic ops, shift right and pass.
// Processes one 4-bit digit per clock, LSB first, behind a start/busy/done handshake.
module alu_digit_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk_2,
  input  logic             res_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             decimal,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             half_carry,
  output logic             zero,
  output logic             negative
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_EOR = 3'd4;
  localparam logic [2:0] OP_SR  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;
  logic   w_accept;
  logic   w_lastDigit;

  // Operand a carries one extra zero bit on top so SR can always borrow bit 4.
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_dec;
  logic             r_cin;
  logic             r_a0;
  logic             r_carry;
  logic             r_half;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shadow;

  logic [3:0]       w_aDig;
  logic [3:0]       w_bx;
  logic [4:0]       w_sum;
  logic [4:0]       w_adj;
  logic             w_isSub;
  logic             w_isArith;
  logic [3:0]       w_digit;
  logic             w_carryNext;
  logic             w_ovfDig;
  logic [WIDTH-1:0] w_nextShadow;

  always_ff @(posedge clk_2 or negedge res_n) begin
    if (!res_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // The DONE cycle may also accept a new request so operations can run back to back.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_lastDigit) w_nextState = S_DONE;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = S_RUN;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_lastDigit = (r_cnt == CW'(DIGITS - 1));
  assign w_aDig      = r_a[3:0];
  assign w_isSub     = (r_op == OP_SUB);
  assign w_isArith   = (r_op == OP_ADD) || w_isSub;
  assign w_bx        = w_isSub ? ~r_b[3:0] : r_b[3:0];
  assign w_sum       = {1'b0, w_aDig} + {1'b0, w_bx} + {4'b0000, r_carry};
  assign w_adj       = w_sum + 5'd6;
  assign w_ovfDig    = (w_aDig[3] == w_bx[3]) && (w_sum[3] != w_aDig[3]);

  always_comb begin
    w_digit     = w_aDig;
    w_carryNext = r_carry;
    case (r_op)
      OP_ADD, OP_SUB: begin
        if (r_dec && !w_isSub) begin
          if (w_sum > 5'd9) begin
            w_digit     = w_adj[3:0];
            w_carryNext = 1'b1;
          end else begin
            w_digit     = w_sum[3:0];
            w_carryNext = 1'b0;
          end
        end else if (r_dec) begin
          w_carryNext = w_sum[4];
          w_digit     = w_sum[4] ? w_sum[3:0] : (w_sum[3:0] - 4'd6);
        end else begin
          w_digit     = w_sum[3:0];
          w_carryNext = w_sum[4];
        end
      end
      OP_AND:  w_digit = w_aDig & r_b[3:0];
      OP_OR:   w_digit = w_aDig | r_b[3:0];
      OP_EOR:  w_digit = w_aDig ^ r_b[3:0];
      OP_SR:   w_digit = r_a[4:1];
      default: w_digit = w_aDig;
    endcase
  end

  // Digits enter the shadow at the top and slide down, so digit 0 lands at the bottom.
  assign w_nextShadow = (r_shadow >> 4) | (WIDTH'(w_digit) << (WIDTH - 4));

  always_ff @(posedge clk_2 or negedge res_n) begin
    if (!res_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_dec      <= 1'b0;
      r_cin      <= 1'b0;
      r_a0       <= 1'b0;
      r_carry    <= 1'b0;
      r_half     <= 1'b0;
      r_cnt      <= '0;
      r_shadow   <= '0;
      result     <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      half_carry <= 1'b0;
      zero       <= 1'b1;
      negative   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= {1'b0, a};
      r_b      <= b;
      r_op     <= op;
      r_dec    <= decimal;
      r_cin    <= carry_in;
      r_a0     <= a[0];
      r_carry  <= carry_in;
      r_half   <= 1'b0;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else if (r_state == S_RUN) begin
      r_a      <= r_a >> 4;
      r_b      <= r_b >> 4;
      r_carry  <= w_carryNext;
      r_shadow <= w_nextShadow;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == '0) r_half <= w_carryNext;
      if (w_lastDigit) begin
        result     <= w_nextShadow;
        zero       <= (w_nextShadow == '0);
        negative   <= w_nextShadow[WIDTH-1];
        overflow   <= w_isArith && w_ovfDig;
        half_carry <= w_isArith && ((r_cnt == '0) ? w_carryNext : r_half);
        if (w_isArith)           carry_out <= w_carryNext;
        else if (r_op == OP_SR)  carry_out <= r_a0;
        else                     carry_out <= r_cin;
      end
    end
  end

endmodule

// File: tb/tb_alu_digit_serial.sv
// Directed self-checking bench for alu_digit_serial (WIDTH=16 and WIDTH=8 instances).
module tb_alu_digit_serial;

  logic        clk = 1'b0;
  logic        resN;
  logic        start;
  logic [2:0]  op;
  logic        dec;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy, done, cout, ovf, half, zero, neg;
  logic [15:0] result;

  logic        start8;
  logic [2:0]  op8;
  logic        dec8;
  logic        cin8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8, done8, cout8, ovf8, half8, zero8, neg8;
  logic [7:0]  result8;

  int nTests = 0;
  int nFail  = 0;
  int cyc;
  bit doneSeen;

  always #5 clk = ~clk;

  alu_digit_serial #(.WIDTH(16)) dut16 (
    .clk_2(clk), .res_n(resN), .start(start), .op(op), .decimal(dec), .carry_in(cin),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .carry_out(cout),
    .overflow(ovf), .half_carry(half), .zero(zero), .negative(neg)
  );

  alu_digit_serial #(.WIDTH(8)) dut8 (
    .clk_2(clk), .res_n(resN), .start(start8), .op(op8), .decimal(dec8), .carry_in(cin8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result(result8), .carry_out(cout8),
    .overflow(ovf8), .half_carry(half8), .zero(zero8), .negative(neg8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a request; returns #1 after the accept edge.
  task automatic applyStimulus(input bit waitNeg, input logic [2:0] o, input logic d,
                               input logic c, input logic [15:0] va, input logic [15:0] vb);
    if (waitNeg) @(negedge clk);
    op = o; dec = d; cin = c; a = va; b = vb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedge samples after the accept edge until done, bounded.
  task automatic waitDone(input int already, output int n);
    n = already;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
  endtask

  task automatic waitDone8(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done8) break;
    end
  endtask

  task automatic checkFlags(input string tag, input logic [15:0] r, input logic c,
                            input logic v, input logic h, input logic z, input logic n);
    checkOutput({tag, "_result"}, 32'(result), 32'(r));
    checkOutput({tag, "_C"}, 32'(cout), 32'(c));
    checkOutput({tag, "_V"}, 32'(ovf), 32'(v));
    checkOutput({tag, "_H"}, 32'(half), 32'(h));
    checkOutput({tag, "_Z"}, 32'(zero), 32'(z));
    checkOutput({tag, "_N"}, 32'(neg), 32'(n));
  endtask

  initial begin
    resN = 1'b0; start = 1'b0; op = '0; dec = 1'b0; cin = 1'b0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; dec8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkFlags("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst8_zero", 32'(zero8), 32'd1);
    @(negedge clk) resN = 1'b1;

    // Binary add with signed overflow, latency check
    applyStimulus(1, 3'd0, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
    checkOutput("add_busy_run", 32'(busy), 32'd1);
    checkOutput("add_done_run", 32'(done), 32'd0);
    waitDone(0, cyc);
    checkOutput("add_latency", 32'(cyc), 32'd5);
    checkOutput("add_busy_done", 32'(busy), 32'd1);
    checkFlags("add", 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("add_done_pulse", 32'(done), 32'd0);
    checkOutput("add_busy_after", 32'(busy), 32'd0);

    // BCD add; outputs must hold the previous result during RUN
    applyStimulus(1, 3'd0, 1'b1, 1'b0, 16'h0999, 16'h0001);
    @(negedge clk);
    checkOutput("dadd_hold_result", 32'(result), 32'h8000);
    waitDone(1, cyc);
    checkOutput("dadd_latency", 32'(cyc), 32'd5);
    checkFlags("dadd", 16'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    applyStimulus(1, 3'd1, 1'b1, 1'b1, 16'h0000, 16'h0001);
    waitDone(0, cyc);
    checkFlags("dsub", 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1, 3'd1, 1'b0, 1'b1, 16'h1234, 16'h1234);
    waitDone(0, cyc);
    checkFlags("sub", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    applyStimulus(1, 3'd5, 1'b0, 1'b0, 16'h8001, 16'hFFFF);
    waitDone(0, cyc);
    checkFlags("sr", 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1, 3'd2, 1'b1, 1'b1, 16'h0F0F, 16'h00FF);
    waitDone(0, cyc);
    checkFlags("and", 16'h000F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1, 3'd3, 1'b0, 1'b0, 16'hF000, 16'h000F);
    waitDone(0, cyc);
    checkFlags("or", 16'hF00F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1, 3'd4, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    waitDone(0, cyc);
    checkFlags("eor", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    applyStimulus(1, 3'd7, 1'b1, 1'b0, 16'hABCD, 16'h1111);
    waitDone(0, cyc);
    checkFlags("pass", 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start pulsed mid-RUN with new operands must be ignored
    applyStimulus(1, 3'd0, 1'b0, 1'b0, 16'h1111, 16'h2222);
    @(negedge clk);
    @(negedge clk);
    op = 3'd1; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(3, cyc);
    checkOutput("ignore_latency", 32'(cyc), 32'd5);
    checkOutput("ignore_result", 32'(result), 32'h3333);

    // Back-to-back: start held in the DONE cycle
    applyStimulus(0, 3'd0, 1'b0, 1'b1, 16'h0001, 16'h0002);
    waitDone(0, cyc);
    checkOutput("b2b_latency", 32'(cyc), 32'd5);
    checkOutput("b2b_result", 32'(result), 32'h0004);

    // Reset mid-RUN aborts without a done pulse
    applyStimulus(1, 3'd0, 1'b0, 1'b0, 16'h1234, 16'h1111);
    @(negedge clk);
    @(negedge clk);
    resN = 1'b0;
    #1;
    checkOutput("rrst_busy", 32'(busy), 32'd0);
    checkOutput("rrst_done", 32'(done), 32'd0);
    checkFlags("rrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk) resN = 1'b1;
    doneSeen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) doneSeen = 1'b1;
    end
    checkOutput("rrst_no_done", 32'(doneSeen), 32'd0);
    applyStimulus(1, 3'd0, 1'b0, 1'b0, 16'h1234, 16'h1111);
    waitDone(0, cyc);
    checkOutput("rrst_after_latency", 32'(cyc), 32'd5);
    checkFlags("rrst_after", 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=8 instance: BCD 99 + 01
    @(negedge clk);
    op8 = 3'd0; dec8 = 1'b1; cin8 = 1'b0; a8 = 8'h99; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    waitDone8(cyc);
    checkOutput("w8_latency", 32'(cyc), 32'd3);
    checkOutput("w8_result", 32'(result8), 32'h00);
    checkOutput("w8_C", 32'(cout8), 32'd1);
    checkOutput("w8_Z", 32'(zero8), 32'd1);
    checkOutput("w8_H", 32'(half8), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
